parking_event_encoder: RTL and testbench
========================================

Name: parking_event_encoder

Overview:
Sensor front-end that feeds the parking occupancy FSM. It debounces the raw entry-loop detector and the four per-slot exit-request detectors, then queues the resulting events. It serialises them into one-at-a-time entry_sensor / exit_sensor / exit_location requests and holds each until the FSM acknowledges it with door_open or a timeout expires. Exits have priority over entries, matching the FSM's own priority.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed before a debounced level changes (>=1)
ACK_TIMEOUT, 8, cycles a request is held in REQ without door_open before it is rejected (>=1)
GAP_CYCLES, 1, idle cycles forced between consecutive requests (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
entry_loop_raw  in  1  raw, asynchronous vehicle-at-entry detector
exit_req_raw  in  4  raw, asynchronous exit detectors; bit i = car leaving slot i
door_open  in  1  FSM accept/acknowledge for the current request
entry_sensor  out  1  registered entry request to the FSM
exit_sensor  out  1  registered exit request to the FSM
exit_location  out  2  slot index of the current exit request; 0 when exit_sensor=0
busy  out  1  1 when state != IDLE or any pending bit is set
reject  out  1  one-cycle pulse when a request times out
overflow  out  1  one-cycle pulse when an event arrives for a source already pending and not in service

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0.
  - Synchronisers, debounced levels, debounce counters, pending bits and timers cleared.
  - State = IDLE.
- Input conditioning, per raw input (5 total):
  - 2-FF synchroniser, then a debounce counter.
  - The counter increments while the synchronised value differs from the debounced level and clears otherwise.
  - The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
- Pending bits (entry_pend, exit_pend[3:0]):
  - A 0->1 transition of a debounced level sets its pending bit one edge later.
  - Falling edges are ignored.
  - A rising edge on a bit that is already pending and not being served: the bit stays set and overflow pulses.
- Latency: with the FSM idle, a clean raw rising edge drives the request output high after edge DEBOUNCE_CYCLES+4. Edge 1 is the edge that first samples the new raw value. For DEBOUNCE_CYCLES=4 this is edge 8.
- State machine (IDLE, REQ, GAP):
  - IDLE:
    - If any exit_pend bit is set: latch the lowest set index i. Next edge: exit_sensor=1, exit_location=i, go to REQ.
    - Else if entry_pend is set: next edge entry_sensor=1, go to REQ.
    - Else stay in IDLE, outputs 0.
  - REQ: outputs held constant; the timer counts cycles in REQ.
    - door_open=1 sampled: clear the served pending bit; next edge outputs 0, go to GAP.
    - Timer reaches ACK_TIMEOUT with no door_open: clear the served pending bit, pulse reject for 1 cycle, outputs 0, go to GAP.
    - The timeout path is normal operation, e.g. entry while the lot is full, or exit from an empty slot.
  - GAP: outputs 0 for GAP_CYCLES cycles, then IDLE.
- Handshake boundary conditions:
  - door_open in IDLE or GAP is ignored.
  - entry_sensor and exit_sensor are never high together.
  - exit_location changes only on entry to REQ.
- Simultaneous events:
  - A set and a clear on the same pending bit in the same cycle: set wins. The event is re-requested after GAP and overflow does not pulse.
  - Multiple new exits in one cycle: all pending bits are set; they are served lowest index first.
- Reset mid-request: all outputs drop asynchronously and all pending events are discarded.

Optional Feature:
- Macro: PARKING_EXIT_RR_EN.
- Defined: the exit slot is chosen round-robin. The search starts at (last served exit index + 1) mod 4; the pointer resets to 0.
- Undefined: fixed lowest-index priority, as described above.
- Entry arbitration is unchanged in both builds.

Decomposition:
- Shared package parking_pkg holds:
  - SLOT_COUNT=4 and SLOT_IDX_W=2;
  - the encoder state encoding (IDLE=2'd0, REQ=2'd1, GAP=2'd2);
  - a slot-index priority-pick function.
- One sub-module, parking_debounce (synchroniser + counter, parameter DEBOUNCE_CYCLES), instanced 5 times.

Test Plan:
1. Entry, FSM acks: entry_loop_raw 0->1 and held, door_open=1 on the first REQ cycle -> entry_sensor high at edge 8, low next edge; busy then falls after GAP.
2. Exit priority: exit_req_raw=4'b0100 and entry_loop_raw rise together; ack each request.
   - First request: exit_sensor=1, exit_location=2.
   - After 1 GAP cycle: entry_sensor=1.
3. Timeout: entry request with door_open held 0 -> entry_sensor high exactly 8 cycles, reject pulses once, entry_pend cleared, no retry.
4. Bounce rejection: exit_req_raw[1] toggles every 2 cycles for 20 cycles, then settles at 0 -> exit_sensor never asserts.
5. Overflow: exit 0 in REQ (no ack), exit 3 pending, exit 3 re-rises after a clean fall -> overflow pulses once.
   - After exit 0 is acked, exit_location=3 is served once.
6. Reset in REQ: assert reset with exit_sensor=1 -> all outputs 0 immediately; no request after release until a new raw edge.
   - Under PARKING_EXIT_RR_EN: pending exits 4'b1011 after serving index 1 -> next exit_location=3, then 0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared slot sizing, encoder state encoding and exit-slot picker
// for the parking sensor front-end.
package parking_pkg;
    localparam int SLOT_COUNT = 4;
    localparam int SLOT_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } enc_state_t;

    // First set bit of pend, searching upward from start with wrap-around.
    function automatic logic [SLOT_IDX_W-1:0] pick_slot(
        input logic [SLOT_COUNT-1:0] pend,
        input logic [SLOT_IDX_W-1:0] start
    );
        logic [SLOT_IDX_W-1:0] idx;
        logic [SLOT_IDX_W-1:0] sel;
        logic                  found;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < SLOT_COUNT; k++) begin
            idx = start + SLOT_IDX_W'(k);
            if (!found && pend[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction
endpackage

// File: rtl/parking_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer; the level
// flips after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module parking_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/parking_event_encoder.sv
// Debounces entry/exit detectors, queues events and serialises them as
// held requests to the occupancy FSM. Build option: PARKING_EXIT_RR_EN.
module parking_event_encoder
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 8,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  entry_loop_raw,
    input  logic [SLOT_COUNT-1:0] exit_req_raw,
    input  logic                  door_open,
    output logic                  entry_sensor,
    output logic                  exit_sensor,
    output logic [SLOT_IDX_W-1:0] exit_location,
    output logic                  busy,
    output logic                  reject,
    output logic                  overflow
);
    localparam int SRC_N = SLOT_COUNT + 1;
    localparam int ENTRY = SLOT_COUNT;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    logic [SRC_N-1:0] raw_vec;
    logic [SRC_N-1:0] lvl;
    logic [SRC_N-1:0] lvl_q;
    logic [SRC_N-1:0] rise;
    logic [SRC_N-1:0] pend;
    logic [SRC_N-1:0] sel;
    logic [SRC_N-1:0] sel_n;
    logic [SRC_N-1:0] clear;
    logic [SRC_N-1:0] in_service;

    enc_state_t state;
    enc_state_t state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_n;

    logic                  entry_n;
    logic                  exit_n;
    logic [SLOT_IDX_W-1:0] loc_n;
    logic                  reject_n;
    logic [SLOT_IDX_W-1:0] search_start;
    logic [SLOT_IDX_W-1:0] pick;

    assign raw_vec = {entry_loop_raw, exit_req_raw};

    for (genvar g = 0; g < SRC_N; g++) begin : g_deb
        parking_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[g]),
            .level(lvl[g])
        );
    end

    assign rise       = lvl & ~lvl_q;
    assign in_service = (state == REQ) ? sel : '0;
    assign busy       = (state != IDLE) || (|pend);
    assign pick       = pick_slot(pend[SLOT_COUNT-1:0], search_start);

`ifdef PARKING_EXIT_RR_EN
    logic [SLOT_IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == IDLE && |pend[SLOT_COUNT-1:0]) begin
            rr_ptr <= pick + SLOT_IDX_W'(1);
        end
    end

    assign search_start = rr_ptr;
`else
    assign search_start = '0;
`endif

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        gap_n    = gap_cnt;
        sel_n    = sel;
        entry_n  = entry_sensor;
        exit_n   = exit_sensor;
        loc_n    = exit_location;
        reject_n = 1'b0;
        clear    = '0;
        unique case (state)
            IDLE: begin
                if (|pend[SLOT_COUNT-1:0]) begin
                    state_n = REQ;
                    timer_n = '0;
                    exit_n  = 1'b1;
                    loc_n   = pick;
                    sel_n   = SRC_N'(1) << pick;
                end else if (pend[ENTRY]) begin
                    state_n = REQ;
                    timer_n = '0;
                    entry_n = 1'b1;
                    sel_n   = SRC_N'(1) << ENTRY;
                end
            end
            REQ: begin
                // Acknowledge and timeout both retire the event.
                if (door_open || timer == T_LAST) begin
                    state_n  = GAP;
                    gap_n    = '0;
                    clear    = sel;
                    reject_n = !door_open;
                    entry_n  = 1'b0;
                    exit_n   = 1'b0;
                    loc_n    = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == G_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            gap_cnt       <= '0;
            sel           <= '0;
            pend          <= '0;
            lvl_q         <= '0;
            entry_sensor  <= 1'b0;
            exit_sensor   <= 1'b0;
            exit_location <= '0;
            reject        <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            gap_cnt       <= gap_n;
            sel           <= sel_n;
            lvl_q         <= lvl;
            // A set in the same cycle as the clear wins.
            pend          <= (pend & ~clear) | rise;
            entry_sensor  <= entry_n;
            exit_sensor   <= exit_n;
            exit_location <= loc_n;
            reject        <= reject_n;
            overflow      <= |(rise & pend & ~in_service);
        end
    end
endmodule

// File: tb/tb_parking_event_encoder.sv
// Self-checking bench for parking_event_encoder: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_parking_event_encoder;
    localparam int DEB  = 4;
    localparam int TMO  = 8;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_loop_raw = 1'b0;
    logic [3:0] exit_req_raw = 4'b0000;
    logic       door_open = 1'b0;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] exit_location;
    logic       busy;
    logic       reject;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parking_event_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .ACK_TIMEOUT    (TMO),
        .GAP_CYCLES     (GAPC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_loop_raw(entry_loop_raw),
        .exit_req_raw (exit_req_raw),
        .door_open    (door_open),
        .entry_sensor (entry_sensor),
        .exit_sensor  (exit_sensor),
        .exit_location(exit_location),
        .busy         (busy),
        .reject       (reject),
        .overflow     (overflow)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic       ent;
        logic [3:0] ex;
        logic       door;
        logic [7:0] edges;
        logic       e_ent;
        logic       e_ex;
        logic [1:0] e_loc;
        logic       e_busy;
    } vec_t;

    vec_t vt [13];

    // Behavioural reference: synchroniser as a 2-deep delay line, debounce
    // as a run length, arbitration as request phases with elapsed counts.
    bit [4:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_pend;
    int       m_run [5];
    int       m_phase, m_cur, m_held, m_cool, m_rr, m_loc;
    bit       m_ent, m_ex, m_rej, m_ovf;

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_prev = 0; m_pend = 0;
        for (int s = 0; s < 5; s++) m_run[s] = 0;
        m_phase = 0; m_cur = -1; m_held = 0; m_cool = 0; m_rr = 0;
        m_loc = 0; m_ent = 0; m_ex = 0; m_rej = 0; m_ovf = 0;
    endtask

    task automatic m_step(input bit [4:0] raw, input bit door);
        bit [4:0] rise, clr;
        int       start, pk;
        bit       ovf;
        rise = m_lvl & ~m_lvl_prev;
        clr  = 0;
        ovf  = 0;
        for (int s = 0; s < 5; s++)
            if (rise[s] && m_pend[s] && !(m_phase == 1 && m_cur == s)) ovf = 1;
        m_rej = 0;
        if (m_phase == 1) begin
            if (door || m_held + 1 == TMO) begin
                clr[m_cur] = 1'b1;
                m_rej = !door;
                m_phase = 2; m_cool = 0;
                m_ent = 0; m_ex = 0; m_loc = 0;
            end else begin
                m_held++;
            end
        end else if (m_phase == 2) begin
            if (m_cool + 1 == GAPC) m_phase = 0;
            else m_cool++;
        end else begin
`ifdef PARKING_EXIT_RR_EN
            start = m_rr;
`else
            start = 0;
`endif
            pk = -1;
            for (int k = 0; k < 4; k++)
                if (pk < 0 && m_pend[(start + k) % 4]) pk = (start + k) % 4;
            if (pk >= 0) begin
                m_cur = pk; m_ex = 1; m_loc = pk;
                m_phase = 1; m_held = 0;
                m_rr = (pk + 1) % 4;
            end else if (m_pend[4]) begin
                m_cur = 4; m_ent = 1;
                m_phase = 1; m_held = 0;
            end
        end
        m_ovf = ovf;
        m_pend = (m_pend & ~clr) | rise;
        m_lvl_prev = m_lvl;
        for (int s = 0; s < 5; s++) begin
            if (m_s2[s] != m_lvl[s]) begin
                m_run[s]++;
                if (m_run[s] == DEB) begin
                    m_lvl[s] = ~m_lvl[s];
                    m_run[s] = 0;
                end
            end else begin
                m_run[s] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    int       hi, rej, ovf, bsy, first, prev;
    int       served [$];
    bit [4:0] rraw;
    bit       rdoor;

    initial begin
        vt[0]  = '{1'b1, 4'b0000, 1'b0, 8'd7,  1'b0, 1'b0, 2'd0, 1'b1};
        vt[1]  = '{1'b1, 4'b0000, 1'b0, 8'd1,  1'b1, 1'b0, 2'd0, 1'b1};
        vt[2]  = '{1'b1, 4'b0000, 1'b1, 8'd1,  1'b0, 1'b0, 2'd0, 1'b1};
        vt[3]  = '{1'b1, 4'b0000, 1'b0, 8'd1,  1'b0, 1'b0, 2'd0, 1'b0};
        vt[4]  = '{1'b0, 4'b0000, 1'b0, 8'd10, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[5]  = '{1'b1, 4'b0100, 1'b0, 8'd7,  1'b0, 1'b0, 2'd0, 1'b1};
        vt[6]  = '{1'b1, 4'b0100, 1'b0, 8'd1,  1'b0, 1'b1, 2'd2, 1'b1};
        vt[7]  = '{1'b1, 4'b0100, 1'b1, 8'd1,  1'b0, 1'b0, 2'd0, 1'b1};
        vt[8]  = '{1'b1, 4'b0100, 1'b0, 8'd1,  1'b0, 1'b0, 2'd0, 1'b1};
        vt[9]  = '{1'b1, 4'b0100, 1'b0, 8'd1,  1'b1, 1'b0, 2'd0, 1'b1};
        vt[10] = '{1'b1, 4'b0100, 1'b1, 8'd1,  1'b0, 1'b0, 2'd0, 1'b1};
        vt[11] = '{1'b1, 4'b0100, 1'b0, 8'd1,  1'b0, 1'b0, 2'd0, 1'b0};
        vt[12] = '{1'b0, 4'b0000, 1'b0, 8'd10, 1'b0, 1'b0, 2'd0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.entry", entry_sensor, 0);
        chk("reset.exit", exit_sensor, 0);
        chk("reset.loc", exit_location, 0);
        chk("reset.busy", busy, 0);
        chk("reset.reject", reject, 0);
        chk("reset.overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // Entry ack then exit-over-entry priority, as a timeline table.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            entry_loop_raw = vt[i].ent;
            exit_req_raw   = vt[i].ex;
            door_open      = vt[i].door;
            repeat (int'(vt[i].edges)) @(posedge clk);
            #1;
            chk($sformatf("vec%0d.entry", i), entry_sensor, vt[i].e_ent);
            chk($sformatf("vec%0d.exit", i), exit_sensor, vt[i].e_ex);
            chk($sformatf("vec%0d.loc", i), exit_location, vt[i].e_loc);
            chk($sformatf("vec%0d.busy", i), busy, vt[i].e_busy);
        end

        // Timeout: held exactly TMO cycles, one reject, no retry.
        @(negedge clk);
        entry_loop_raw = 1'b1;
        door_open = 1'b0;
        hi = 0; rej = 0; first = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (entry_sensor && first < 0) first = c;
            hi  += int'(entry_sensor);
            rej += int'(reject);
        end
        chk("timeout.latency", first, DEB + 4);
        chk("timeout.high_cycles", hi, TMO);
        chk("timeout.reject_pulses", rej, 1);
        chk("timeout.busy_after", busy, 0);
        @(negedge clk);
        entry_loop_raw = 1'b0;
        repeat (12) @(posedge clk);

        // Bounce on exit 1 never qualifies.
        hi = 0; bsy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exit_req_raw[1] = (c < 20) && ((c / 2) % 2 == 0);
            @(posedge clk);
            #1;
            hi  += int'(exit_sensor);
            bsy += int'(busy);
        end
        chk("bounce.exit_cycles", hi, 0);
        chk("bounce.busy_cycles", bsy, 0);

        // Overflow: exit 3 re-rises while exit 0 is in service.
        ovf = 0; rej = 0; prev = 0;
        served.delete();
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            entry_loop_raw  = 1'b1;
            exit_req_raw[0] = (c >= 1);
            exit_req_raw[3] = (c >= 1 && c <= 6) || (c >= 13);
            door_open = exit_sensor && (exit_location == 2'd3 || ovf > 0);
            @(posedge clk);
            #1;
            ovf += int'(overflow);
            rej += int'(reject);
            if (exit_sensor && prev == 0) served.push_back(int'(exit_location));
            prev = int'(exit_sensor);
        end
        chk("ovf.pulses", ovf, 1);
        chk("ovf.entry_reject", rej, 1);
        chk("ovf.served_count", served.size(), 2);
        if (served.size() == 2) begin
            chk("ovf.first_loc", served[0], 0);
            chk("ovf.second_loc", served[1], 3);
        end
        @(negedge clk);
        entry_loop_raw = 1'b0;
        exit_req_raw = 4'b0000;
        door_open = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("ovf.busy_after", busy, 0);

        // Reset while an exit request is up.
        @(negedge clk);
        exit_req_raw = 4'b0010;
        first = -1;
        for (int c = 1; c <= 20 && first < 0; c++) begin
            @(posedge clk);
            #1;
            if (exit_sensor) first = c;
        end
        chk("rst.req_latency", first, DEB + 4);
        #2;
        reset = 1'b1;
        #1;
        chk("rst.exit_async", exit_sensor, 0);
        chk("rst.loc_async", exit_location, 0);
        chk("rst.busy_async", busy, 0);
        exit_req_raw = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            hi += int'(exit_sensor) + int'(entry_sensor) + int'(busy);
        end
        chk("rst.quiet_after", hi, 0);

        @(negedge clk);
        exit_req_raw = 4'b0010;
        first = -1;
        for (int c = 1; c <= 20 && first < 0; c++) begin
            @(posedge clk);
            #1;
            if (exit_sensor) first = c;
        end
        chk("rst.new_edge_latency", first, DEB + 4);
        chk("rst.new_edge_loc", exit_location, 1);
        @(negedge clk);
        door_open = 1'b1;
        @(negedge clk);
        door_open = 1'b0;
        exit_req_raw = 4'b0000;
        repeat (12) @(posedge clk);

        // Three exits at once after slot 1 was last served.
        served.delete();
        prev = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            exit_req_raw = 4'b1011;
            door_open = exit_sensor;
            @(posedge clk);
            #1;
            if (exit_sensor && prev == 0) served.push_back(int'(exit_location));
            prev = int'(exit_sensor);
        end
        chk("multi.count", served.size(), 3);
        if (served.size() == 3) begin
`ifdef PARKING_EXIT_RR_EN
            chk("multi.order0", served[0], 3);
            chk("multi.order1", served[1], 0);
            chk("multi.order2", served[2], 1);
`else
            chk("multi.order0", served[0], 0);
            chk("multi.order1", served[1], 1);
            chk("multi.order2", served[2], 3);
`endif
        end
        @(negedge clk);
        exit_req_raw = 4'b0000;
        door_open = 1'b0;

        // Randomized run against the model.
        reset = 1'b1;
        entry_loop_raw = 1'b0;
        rraw = 0;
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000 && n_fail < 20; c++) begin
            @(negedge clk);
            chk($sformatf("rand%0d.outs", c),
                int'({entry_sensor, exit_sensor, exit_location,
                      reject, overflow, busy}),
                int'({m_ent, m_ex, 2'(m_loc), m_rej, m_ovf,
                      (m_phase != 0) || (m_pend != 0)}));
            for (int s = 0; s < 5; s++)
                if ($urandom_range(0, 9) == 0) rraw[s] = ~rraw[s];
            rdoor = ($urandom_range(0, 3) == 0);
            entry_loop_raw = rraw[4];
            exit_req_raw   = rraw[3:0];
            door_open      = rdoor;
            m_step(rraw, rdoor);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
